// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack for the CPU front end.
// Supports absolute load, STEP increment, relative branch, call/return through
// a DEPTH-entry LIFO, a stall that freezes everything, a sticky error flag for
// stack overflow/underflow, and a one-cycle wrap pulse for inc/branch.
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int STEP  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic [WIDTH-1:0]           offset,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       branch,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       stall,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       err,
  output logic                       wrap
);

  // DEPTH is a power of two, so the count needs exactly one bit more than the index.
  localparam int                DW      = $clog2(DEPTH+1);
  localparam int                AW      = $clog2(DEPTH);
  localparam logic [WIDTH:0]    STEP_X  = (WIDTH+1)'(STEP);
  localparam logic [DW-1:0]     DEPTH_D = DW'(DEPTH);

  // pc + STEP with the carry out of the top bit kept in the extra MSB.
  function automatic logic [WIDTH:0] step_add(input logic [WIDTH-1:0] a);
    return {1'b0, a} + STEP_X;
  endfunction

  // A relative jump wrapped if a forward move landed lower or a backward
  // move landed higher than where it started.
  function automatic logic branch_wrap(input logic [WIDTH-1:0]        a,
                                       input logic signed [WIDTH-1:0] off,
                                       input logic [WIDTH-1:0]        r);
    return off[WIDTH-1] ? (r > a) : (r < a);
  endfunction

  logic [WIDTH-1:0]        pc_p0;
  logic [DW-1:0]           depth_p0;
  logic                    err_p0;
  logic                    wrap_p0;
  logic [WIDTH-1:0]        stack_mem [DEPTH];

  logic [WIDTH-1:0]        pc_nxt;
  logic [DW-1:0]           depth_nxt;
  logic                    err_nxt;
  logic                    wrap_nxt;
  logic                    push_en;

  logic [WIDTH:0]          inc_sum;
  logic signed [WIDTH-1:0] off_s;
  logic [WIDTH-1:0]        br_sum;
  logic [AW-1:0]           push_idx;
  logic [AW-1:0]           pop_idx;

  assign inc_sum  = step_add(pc_p0);
  assign off_s    = offset;
  assign br_sum   = pc_p0 + offset;
  // Only the low index bits address the array; push happens only when not
  // full and pop only when not empty, so the truncation never aliases.
  assign push_idx = depth_p0[AW-1:0];
  assign pop_idx  = depth_p0[AW-1:0] - AW'(1);

  assign full  = (depth_p0 == DEPTH_D);
  assign empty = (depth_p0 == '0);

  // Next-state selection: stall freezes, otherwise load > call > ret > branch > inc.
  always_comb begin
    pc_nxt    = pc_p0;
    depth_nxt = depth_p0;
    err_nxt   = err_p0;
    wrap_nxt  = 1'b0;
    push_en   = 1'b0;
    if (!stall) begin
      if (load) begin
        pc_nxt = in;
      end else if (call) begin
        if (full) begin
          err_nxt = 1'b1;
        end else begin
          push_en   = 1'b1;
          depth_nxt = depth_p0 + DW'(1);
          pc_nxt    = in;
        end
      end else if (ret) begin
        if (empty) begin
          err_nxt = 1'b1;
        end else begin
          pc_nxt    = stack_mem[pop_idx];
          depth_nxt = depth_p0 - DW'(1);
        end
      end else if (branch) begin
        pc_nxt   = br_sum;
        wrap_nxt = branch_wrap(pc_p0, off_s, br_sum);
      end else if (inc) begin
        pc_nxt   = inc_sum[WIDTH-1:0];
        wrap_nxt = inc_sum[WIDTH];
      end
    end
  end

  // Control state: PC, stack depth, sticky error and wrap pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_p0    <= '0;
      depth_p0 <= '0;
      err_p0   <= 1'b0;
      wrap_p0  <= 1'b0;
    end else begin
      pc_p0    <= pc_nxt;
      depth_p0 <= depth_nxt;
      err_p0   <= err_nxt;
      wrap_p0  <= wrap_nxt;
    end
  end

  // Return-address storage; contents are meaningless while depth is zero, so no reset.
  always_ff @(posedge clock) begin
    if (push_en) begin
      stack_mem[push_idx] <= inc_sum[WIDTH-1:0];
    end
  end

  assign out   = pc_p0;
  assign depth = depth_p0;
  assign err   = err_p0;
  assign wrap  = wrap_p0;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack (WIDTH=16, DEPTH=4, STEP=1): a queue-based reference
// model checked every cycle, plus directed vectors with literal expectations.
module tb_pc_stack;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_v;
  logic [W-1:0] offset_v;
  logic         load_v, inc_v, branch_v, call_v, ret_v, stall_v;
  logic [W-1:0] out_v;
  logic [2:0]   depth_v;
  logic         full_v, empty_v, err_v, wrap_v;

  int n_cmp;
  int n_bad;

  pc_stack #(.WIDTH(W), .DEPTH(D), .STEP(1)) dut (
    .clock (clk),
    .reset (rst_n),
    .in    (in_v),
    .offset(offset_v),
    .load  (load_v),
    .inc   (inc_v),
    .branch(branch_v),
    .call  (call_v),
    .ret   (ret_v),
    .stall (stall_v),
    .out   (out_v),
    .depth (depth_v),
    .full  (full_v),
    .empty (empty_v),
    .err   (err_v),
    .wrap  (wrap_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: PC as an integer, stack as a queue.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk[$];
  logic         m_err;
  logic         m_wrap;

  always @(posedge clk or negedge rst_n) begin
    int s;
    if (!rst_n) begin
      m_pc   = '0;
      m_stk.delete();
      m_err  = 1'b0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (stall_v) begin
        // everything holds
      end else if (load_v) begin
        m_pc = in_v;
      end else if (call_v) begin
        if (m_stk.size() == D) m_err = 1'b1;
        else begin
          m_stk.push_back(W'((int'(m_pc) + 1) % 65536));
          m_pc = in_v;
        end
      end else if (ret_v) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else m_pc = m_stk.pop_back();
      end else if (branch_v) begin
        s = int'(m_pc) + int'($signed(offset_v));
        m_wrap = (s < 0) || (s > 65535);
        m_pc = W'((s + 65536) % 65536);
      end else if (inc_v) begin
        s = int'(m_pc) + 1;
        m_wrap = (s > 65535);
        m_pc = W'(s % 65536);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    check("model.out",   32'(out_v),   32'(m_pc));
    check("model.depth", 32'(depth_v), 32'(m_stk.size()));
    check("model.full",  32'(full_v),  32'(m_stk.size() == D));
    check("model.empty", 32'(empty_v), 32'(m_stk.size() == 0));
    check("model.err",   32'(err_v),   32'(m_err));
    check("model.wrap",  32'(wrap_v),  32'(m_wrap));
  end

  task automatic idle();
    load_v = 0; inc_v = 0; branch_v = 0; call_v = 0; ret_v = 0; stall_v = 0;
  endtask

  // One active edge, then settle a little before looking at outputs.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [W-1:0] a);
    idle(); load_v = 1; in_v = a; cycle(); idle();
  endtask

  task automatic do_call(input logic [W-1:0] a);
    idle(); call_v = 1; in_v = a; cycle(); idle();
  endtask

  task automatic do_ret();
    idle(); ret_v = 1; cycle(); idle();
  endtask

  task automatic do_branch(input logic [W-1:0] o);
    idle(); branch_v = 1; offset_v = o; cycle(); idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    in_v = '0;
    offset_v = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst.out",   32'(out_v),   32'h0);
    check("rst.depth", 32'(depth_v), 32'h0);
    check("rst.empty", 32'(empty_v), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #2;

    // Build out=1234, depth=2, then async reset mid-cycle.
    do_load(16'h1000);
    do_call(16'h2000);
    do_call(16'h1234);
    check("pre.out",   32'(out_v),   32'h1234);
    check("pre.depth", 32'(depth_v), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst.out",   32'(out_v),   32'h0);
    check("arst.depth", 32'(depth_v), 32'h0);
    check("arst.empty", 32'(empty_v), 32'h1);
    check("arst.err",   32'(err_v),   32'h0);
    inc_v = 1;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(); check("cnt.1", 32'(out_v), 32'h1);
    cycle(); check("cnt.2", 32'(out_v), 32'h2);
    cycle(); check("cnt.3", 32'(out_v), 32'h3);
    idle();

    // Increment wrap.
    do_load(16'hFFFE);
    inc_v = 1;
    cycle(); check("inc.ffff", 32'(out_v), 32'hFFFF); check("inc.nowrap", 32'(wrap_v), 32'h0);
    cycle(); check("inc.0000", 32'(out_v), 32'h0000); check("inc.wrap",   32'(wrap_v), 32'h1);
    idle();
    cycle(); check("inc.pulse", 32'(wrap_v), 32'h0);

    // Nested calls and returns.
    do_load(16'h0010);
    do_call(16'h0100); check("call1.out", 32'(out_v), 32'h0100); check("call1.depth", 32'(depth_v), 32'h1);
    do_call(16'h0200); check("call2.out", 32'(out_v), 32'h0200); check("call2.depth", 32'(depth_v), 32'h2);
    do_ret();          check("ret1.out",  32'(out_v), 32'h0101);
    do_ret();          check("ret2.out",  32'(out_v), 32'h0011); check("ret2.empty", 32'(empty_v), 32'h1);

    // Overflow.
    do_call(16'h0300);
    do_call(16'h0400);
    do_call(16'h0500);
    do_call(16'h0600);
    check("ovf.full", 32'(full_v), 32'h1);
    check("ovf.err0", 32'(err_v),  32'h0);
    do_call(16'hAAAA);
    check("ovf.out",   32'(out_v),   32'h0600);
    check("ovf.depth", 32'(depth_v), 32'h4);
    check("ovf.err",   32'(err_v),   32'h1);
    do_ret(); check("ovf.ret", 32'(out_v), 32'h0501);

    // Underflow after reset.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2.err", 32'(err_v), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_ret();
    check("unf.out", 32'(out_v), 32'h0);
    check("unf.err", 32'(err_v), 32'h1);

    // Priority: load wins over call/ret/inc.
    do_call(16'h0700);
    load_v = 1; call_v = 1; ret_v = 1; inc_v = 1; in_v = 16'h0500;
    cycle(); idle();
    check("prio.out",   32'(out_v),   32'h0500);
    check("prio.depth", 32'(depth_v), 32'h1);

    // Stall freezes everything.
    stall_v = 1; call_v = 1; in_v = 16'h0900;
    cycle();
    inc_v = 1;
    cycle(); idle();
    check("stall.out",   32'(out_v),   32'h0500);
    check("stall.depth", 32'(depth_v), 32'h1);
    check("stall.err",   32'(err_v),   32'h1);
    check("stall.wrap",  32'(wrap_v),  32'h0);

    // Branches.
    do_load(16'h0100);
    do_branch(16'hFFF0); check("br1.out", 32'(out_v), 32'h00F0); check("br1.wrap", 32'(wrap_v), 32'h0);
    do_load(16'h0005);
    do_branch(16'hFFF0); check("br2.out", 32'(out_v), 32'hFFF5); check("br2.wrap", 32'(wrap_v), 32'h1);
    do_load(16'hFFF0);
    do_branch(16'h0020); check("br3.out", 32'(out_v), 32'h0010); check("br3.wrap", 32'(wrap_v), 32'h1);
    do_branch(16'h0000); check("br4.out", 32'(out_v), 32'h0010); check("br4.wrap", 32'(wrap_v), 32'h0);

    // Stack entry survived loads and branches.
    do_ret();
    check("late.ret",   32'(out_v),   32'h0001);
    check("late.empty", 32'(empty_v), 32'h1);

    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter with a hardware return-address stack for the CPU front end.
- Generalises the 16-bit load/inc/reset PC to any width and a configurable increment step.
- Adds relative branch, call/return with a LIFO of depth DEPTH, stall, and overflow/underflow error reporting.
- Its output drives the instruction-memory address; the decoder drives its control inputs.

Parameters:
- WIDTH, 16, PC and address width in bits (>=4).
- DEPTH, 8, return-stack entries (power of 2, >=2).
- STEP, 1, increment amount applied by inc and by the call return-address computation.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in  input  WIDTH  absolute target for load and call.
- offset  input  WIDTH  two's-complement displacement for branch.
- load  input  1  absolute jump.
- inc  input  1  advance by STEP.
- branch  input  1  relative jump.
- call  input  1  push return address, jump to in.
- ret  input  1  pop return address into PC.
- stall  input  1  freeze all state.
- out  output  WIDTH  current PC.
- depth  output  $clog2(DEPTH+1)  number of valid stack entries.
- full  output  1  depth==DEPTH (combinational from depth).
- empty  output  1  depth==0 (combinational from depth).
- err  output  1  sticky stack overflow/underflow flag.
- wrap  output  1  one-cycle pulse: the last inc or branch crossed 2^WIDTH.

Behaviour:
- Reset: reset low asynchronously forces out=0, depth=0, err=0, wrap=0. Stack RAM contents become don't-care and are unreadable while empty.
- On release, the first update occurs at the first rising edge with reset high.
- State changes only on the rising clock edge, with one-cycle latency: out reflects the operation on the next cycle.
- stall=1: out, depth, err and stack hold; wrap=0. Stall overrides every control input. Reset overrides stall.
- Priority when not stalled: load > call > ret > branch > inc > hold. Only the highest asserted input acts; the rest are ignored that cycle.
- load: out <= in. Stack untouched.
- call, not full: stack[depth] <= out+STEP (mod 2^WIDTH); depth <= depth+1; out <= in.
- call, full: overflow. err <= 1; out, depth and stack hold; the call is dropped.
- ret, not empty: out <= stack[depth-1]; depth <= depth-1.
- ret, empty: underflow. err <= 1; out and depth hold.
- branch: out <= out+offset (mod 2^WIDTH). wrap <= 1 on signed wrap: offset>=0 and result<out, or offset<0 and result>out.
- inc: out <= out+STEP (mod 2^WIDTH). wrap <= 1 on carry out of bit WIDTH-1. Example at WIDTH=16, STEP=1: 16'hFFFF -> 16'h0000 with wrap pulse.
- wrap is 0 in every other cycle, including load, call and ret cycles, even when the return address itself wrapped.
- err clears only by reset. No hardware state is lost when err is set.
- Stack storage is a register array indexed by depth. No combinational path exists from control inputs to out.

Test Plan (WIDTH=16, DEPTH=4, STEP=1):
- Reset low mid-run with out=16'h1234 and depth=2 -> immediately out=0, depth=0, empty=1, err=0, without waiting for a clock edge. Hold inc=1 after release -> out counts 1,2,3 on successive edges.
- out=16'hFFFE, inc for 2 cycles -> out=16'hFFFF then 16'h0000, with wrap=1 only in the cycle out=16'h0000.
- Nested calls:
  - At out=16'h0010, call in=16'h0100 -> out=16'h0100, depth=1.
  - Call in=16'h0200 -> depth=2.
  - ret -> out=16'h0101; ret -> out=16'h0011, empty=1.
- Overflow and underflow:
  - 4 calls -> full=1; 5th call in=16'hAAAA -> out unchanged, depth=4, err=1.
  - After reset, ret with empty -> out holds 0, err=1.
- Priority and stall:
  - load=call=ret=inc=1, in=16'h0500 -> out=16'h0500, depth unchanged.
  - stall=1 with call=1 -> out, depth and err all unchanged.
- Branch: out=16'h0100, offset=16'hFFF0 (-16) -> out=16'h00F0, wrap=0. Then out=16'h0005, offset=16'hFFF0 -> out=16'hFFF5, wrap=1.
